pe_bank_distributor: RTL and testbench

- Downstream of the load controller.
- Accepts the linear word stream the controller produces and scatters it round-robin across the N_PE local PE memory banks.
- Bank address for each word = a programmed base + per-bank word index.
- A small FIFO absorbs bursts; a stall input throttles writes into the banks.

---
 rtl/pe_bank_distributor_if.sv | 31 +++
 rtl/pe_bank_distributor.sv | 210 +++++++++++++++++++++
 tb/tb_pe_bank_distributor.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_bank_distributor_if.sv
//==============================================================================
// Module   : pe_bank_distributor_if
// Brief    : Word-stream input and bank write bus of the PE bank distributor.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pe_bank_distributor_if #(
   parameter int N_PE = 8,
   parameter int WID  = 16,
   parameter int ADDR = 10
);
   logic            s_valid;
   logic [WID-1:0]  s_data;
   logic            s_ready;
   logic [N_PE-1:0] bank_w_en;
   logic [ADDR-1:0] bank_w_addr;
   logic [WID-1:0]  bank_w_data;

   modport master (
      output s_valid, s_data,
      input  s_ready, bank_w_en, bank_w_addr, bank_w_data
   );

   modport slave (
      input  s_valid, s_data,
      output s_ready, bank_w_en, bank_w_addr, bank_w_data
   );
endinterface

`default_nettype wire

// File: rtl/pe_bank_distributor.sv
//==============================================================================
// Module   : pe_bank_distributor
// Brief    : Scatters a linear word stream round-robin over N_PE bank memories
//            through a small FIFO. Optional broadcast mode: DIST_BCAST_EN.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module pe_bank_distributor #(
   parameter int N_PE       = 8,
   parameter int WID        = 16,
   parameter int ADDR       = 10,
   parameter int FIFO_DEPTH = 4
) (
   input  wire logic            clk,
   input  wire logic            rst,
   input  wire logic            cfg_start,
   input  wire logic [ADDR-1:0] cfg_base_addr,
   input  wire logic [ADDR-1:0] cfg_words_per_pe,
`ifdef DIST_BCAST_EN
   input  wire logic            cfg_bcast,
`endif
   input  wire logic            bank_stall,
   output logic                 busy,
   output logic                 done,
   pe_bank_distributor_if.slave bus
);

   localparam int c_PE_W  = (N_PE > 1) ? $clog2(N_PE) : 1;
   localparam int c_PTR_W = $clog2(FIFO_DEPTH);
   localparam int c_CNT_W = c_PTR_W + 1;
   localparam logic [c_PE_W-1:0]  c_LAST_PE = c_PE_W'(N_PE - 1);
   localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_FIN  = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_nxt;

   logic [ADDR-1:0]    r_base;
   logic [ADDR-1:0]    r_count;
   logic [c_PE_W-1:0]  r_pe_idx;
   logic [ADDR-1:0]    r_word_idx;

   logic [WID-1:0]     r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_cnt;

   logic               r_s_ready;
   logic [N_PE-1:0]    r_bank_w_en;
   logic [ADDR-1:0]    r_bank_w_addr;
   logic [WID-1:0]     r_bank_w_data;
   logic               r_busy;
   logic               r_done;

   logic               w_bcast;
   logic               w_start;
   logic               w_push;
   logic               w_pop;
   logic               w_last;
   logic               w_flush;
   logic [c_CNT_W-1:0] w_cnt_nxt;
   logic               w_s_ready_nxt;
   logic [N_PE-1:0]    w_onehot;

`ifdef DIST_BCAST_EN
   logic r_bcast;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bcast <= 1'b0;
      end else if (w_start) begin
         r_bcast <= cfg_bcast;
      end
   end

   assign w_bcast = r_bcast;
`else
   assign w_bcast = 1'b0;
`endif

   assign w_start  = (r_state == S_IDLE) && cfg_start;
   assign w_push   = bus.s_valid && r_s_ready;
   assign w_pop    = (r_state == S_LOAD) && (r_cnt != '0) && !bank_stall;
   assign w_onehot = N_PE'(1) << r_pe_idx;

   // In broadcast mode every pop covers all banks, so only word_idx matters.
   assign w_last = w_pop && (r_word_idx == r_count - ADDR'(1)) &&
                   (w_bcast || (r_pe_idx == c_LAST_PE));

   always_comb begin
      w_state_nxt   = r_state;
      w_flush       = 1'b0;
      w_cnt_nxt     = r_cnt;
      w_s_ready_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (w_start) begin
               w_state_nxt = (cfg_words_per_pe == '0) ? S_FIN : S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_last) begin
               w_state_nxt = S_FIN;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // The FIFO only holds data while a load is running; anything else drops it.
      w_flush = (r_state != S_LOAD) || (w_state_nxt != S_LOAD);
      if (w_flush) begin
         w_cnt_nxt = '0;
      end else begin
         w_cnt_nxt = r_cnt + {{(c_CNT_W-1){1'b0}}, w_push}
                           - {{(c_CNT_W-1){1'b0}}, w_pop};
      end

      w_s_ready_nxt = (w_state_nxt == S_LOAD) && (w_cnt_nxt != c_FULL);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= S_IDLE;
         r_base        <= '0;
         r_count       <= '0;
         r_pe_idx      <= '0;
         r_word_idx    <= '0;
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_cnt         <= '0;
         r_s_ready     <= 1'b0;
         r_bank_w_en   <= '0;
         r_bank_w_addr <= '0;
         r_bank_w_data <= '0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_busy    <= (r_state == S_LOAD);
         r_done    <= (r_state == S_FIN);
         r_s_ready <= w_s_ready_nxt;
         r_cnt     <= w_cnt_nxt;

         if (w_start) begin
            r_base     <= cfg_base_addr;
            r_count    <= cfg_words_per_pe;
            r_pe_idx   <= '0;
            r_word_idx <= '0;
         end else if (w_pop) begin
            if (w_bcast) begin
               r_word_idx <= r_word_idx + ADDR'(1);
            end else if (r_pe_idx == c_LAST_PE) begin
               r_pe_idx   <= '0;
               r_word_idx <= r_word_idx + ADDR'(1);
            end else begin
               r_pe_idx   <= r_pe_idx + c_PE_W'(1);
            end
         end

         if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
         end

         // Address and data hold between writes; only the strobe returns to 0.
         if (w_pop) begin
            r_bank_w_en   <= w_bcast ? {N_PE{1'b1}} : w_onehot;
            r_bank_w_addr <= r_base + r_word_idx;
            r_bank_w_data <= r_mem[r_rd_ptr];
         end else begin
            r_bank_w_en   <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= bus.s_data;
      end
   end

   assign bus.s_ready     = r_s_ready;
   assign bus.bank_w_en   = r_bank_w_en;
   assign bus.bank_w_addr = r_bank_w_addr;
   assign bus.bank_w_data = r_bank_w_data;
   assign busy            = r_busy;
   assign done            = r_done;

endmodule

`default_nettype wire

// File: tb/tb_pe_bank_distributor.sv
//==============================================================================
// Module   : tb_pe_bank_distributor
// Brief    : Self-checking bench for pe_bank_distributor (DIST_BCAST_EN aware).
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pe_bank_distributor;

   localparam int N_PE  = 8;
   localparam int WID   = 16;
   localparam int ADDR  = 10;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            cfg_start = 1'b0;
   logic [ADDR-1:0] cfg_base_addr = '0;
   logic [ADDR-1:0] cfg_words_per_pe = '0;
   logic            cfg_bcast = 1'b0;
   logic            bank_stall = 1'b0;
   logic            busy;
   logic            done;

   pe_bank_distributor_if #(.N_PE(N_PE), .WID(WID), .ADDR(ADDR)) bus ();

   pe_bank_distributor #(
      .N_PE(N_PE), .WID(WID), .ADDR(ADDR), .FIFO_DEPTH(DEPTH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_start       (cfg_start),
      .cfg_base_addr   (cfg_base_addr),
      .cfg_words_per_pe(cfg_words_per_pe),
`ifdef DIST_BCAST_EN
      .cfg_bcast       (cfg_bcast),
`endif
      .bank_stall      (bank_stall),
      .busy            (busy),
      .done            (done),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N_PE-1:0] en;
      logic [ADDR-1:0] addr;
      logic [WID-1:0]  data;
   } wr_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Model state: what the next writes must be, derived from accepted words.
   wr_t             exp_q[$];
   int              cyc = 0;
   bit              has_start = 0;
   bit              has_final = 0;
   int              t_start = 0;
   int              t_final = 0;
   logic [ADDR-1:0] m_base = '0;
   int              m_count = 0;
   bit              m_bcast = 0;
   int              total = 0;
   int              n_acc = 0;
   int              n_wr = 0;
   logic [N_PE-1:0] obs_en   [64];
   logic [ADDR-1:0] obs_addr [64];
   logic [WID-1:0]  obs_data [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One model/compare step per negative clock edge.
   task automatic sample();
      wr_t e;
      int  occ;
      bit  exp_busy, exp_done, exp_rdy;
      @(negedge clk);
      if (!rst) begin
         exp_q.delete();
         has_start = 0;
         has_final = 0;
         n_acc = 0;
         n_wr = 0;
         return;
      end
      cyc++;
      if (bank_stall) chk("stall_blocks_write", 32'(bus.bank_w_en), 32'd0);
      if (bus.bank_w_en != '0) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 32'(bus.bank_w_en), 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("w_en",   32'(bus.bank_w_en),   32'(e.en));
            chk("w_addr", 32'(bus.bank_w_addr), 32'(e.addr));
            chk("w_data", 32'(bus.bank_w_data), 32'(e.data));
         end
         if (n_wr < 64) begin
            obs_en[n_wr]   = bus.bank_w_en;
            obs_addr[n_wr] = bus.bank_w_addr;
            obs_data[n_wr] = bus.bank_w_data;
         end
         n_wr++;
         if (has_start && !has_final && n_wr == total) begin
            has_final = 1;
            t_final = cyc;
         end
      end
      if (has_start && !has_final && total == 0 && cyc == t_start + 1) begin
         has_final = 1;
         t_final = cyc;
      end
      occ = n_acc - n_wr;
      exp_busy = has_start && m_count != 0 && cyc >= t_start + 2 && !(has_final && cyc > t_final);
      exp_done = has_final && cyc == t_final + 1;
      exp_rdy  = has_start && m_count != 0 && cyc >= t_start + 1 &&
                 !(has_final && cyc >= t_final) && occ < DEPTH;
      chk("busy",    32'(busy),        32'(exp_busy));
      chk("done",    32'(done),        32'(exp_done));
      chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
      if (bus.s_valid && bus.s_ready) begin
         if (n_acc < total) begin
            if (m_bcast) begin
               e.en   = '1;
               e.addr = m_base + ADDR'(n_acc);
            end else begin
               e.en   = N_PE'(1) << (n_acc % N_PE);
               e.addr = m_base + ADDR'(n_acc / N_PE);
            end
            e.data = bus.s_data;
            exp_q.push_back(e);
         end
         n_acc++;
      end
      if (cfg_start) begin
         has_start = 1;
         has_final = 0;
         t_start = cyc;
         m_base = cfg_base_addr;
         m_count = int'(cfg_words_per_pe);
         m_bcast = cfg_bcast;
         total = m_bcast ? m_count : m_count * N_PE;
         n_acc = 0;
         n_wr = 0;
         exp_q.delete();
      end
   endtask

   // Entered and left at posedge+1.
   task automatic run_load(input logic [ADDR-1:0] base, input int cnt, input bit bc,
                           input int nwords, input logic [WID-1:0] d0,
                           input int stall_at, input int reset_at);
      int i = 0;
      int wcnt = 0;
      int stall_left = 0;
      int dn = 0;
      bit acc;
      bit fin = 0;
      bit stalled = 0;
      cfg_start = 1'b1;
      cfg_base_addr = base;
      cfg_words_per_pe = ADDR'(cnt);
      cfg_bcast = bc;
      sample();
      @(posedge clk); #1;
      cfg_start = 1'b0;
      bus.s_valid = (i < nwords);
      bus.s_data = d0;
      for (int c = 0; c < 400 && !fin; c++) begin
         sample();
         if (bus.bank_w_en != '0) wcnt++;
         if (done) begin dn++; fin = 1; end
         acc = bus.s_valid && bus.s_ready;
         if (reset_at > 0 && wcnt == reset_at) begin
            #2 rst = 1'b0;
            #1;
            chk("rst_w_en",    32'(bus.bank_w_en),   32'd0);
            chk("rst_w_addr",  32'(bus.bank_w_addr), 32'd0);
            chk("rst_w_data",  32'(bus.bank_w_data), 32'd0);
            chk("rst_s_ready", 32'(bus.s_ready),     32'd0);
            chk("rst_busy",    32'(busy),            32'd0);
            chk("rst_done",    32'(done),            32'd0);
            bus.s_valid = 1'b0;
            bank_stall = 1'b0;
            return;
         end
         if (stall_at > 0 && !stalled && wcnt == stall_at) begin
            stalled = 1;
            stall_left = 6;
         end
         #1;
         bank_stall = (stall_left > 0);
         if (stall_left > 0) stall_left--;
         @(posedge clk); #1;
         if (acc) i++;
         bus.s_valid = (i < nwords);
         bus.s_data = d0 + WID'(i);
      end
      if (!fin) chk("load_timeout", 32'd0, 32'd1);
      bus.s_valid = 1'b0;
      bank_stall = 1'b0;
      repeat (3) begin
         sample();
         if (done) dn++;
         @(posedge clk); #1;
      end
      chk("done_pulses", 32'(dn), 32'd1);
   endtask

   initial begin
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      rst = 1'b0;
      sample();
      chk("init_w_en",    32'(bus.bank_w_en),   32'd0);
      chk("init_w_addr",  32'(bus.bank_w_addr), 32'd0);
      chk("init_s_ready", 32'(bus.s_ready),     32'd0);
      chk("init_busy",    32'(busy),            32'd0);
      chk("init_done",    32'(done),            32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      sample();
      @(posedge clk); #1;

      // Plain round-robin, no stall.
      run_load(10'h010, 2, 0, 16, 16'h0000, 0, 0);
      chk("t1_writes",  32'(n_wr),         32'd16);
      chk("t1_en0",     32'(obs_en[0]),    32'h01);
      chk("t1_en7",     32'(obs_en[7]),    32'h80);
      chk("t1_en9",     32'(obs_en[9]),    32'h02);
      chk("t1_addr7",   32'(obs_addr[7]),  32'h010);
      chk("t1_addr8",   32'(obs_addr[8]),  32'h011);
      chk("t1_data15",  32'(obs_data[15]), 32'h000F);

      // Stall burst after the third write.
      run_load(10'h010, 2, 0, 16, 16'h0040, 3, 0);
      chk("t2_writes",  32'(n_wr),         32'd16);
      chk("t2_data4",   32'(obs_data[4]),  32'h0044);
      chk("t2_addr15",  32'(obs_addr[15]), 32'h011);

      // Zero-length load.
      run_load(10'h055, 0, 0, 0, 16'h0000, 0, 0);
      chk("t3_writes",  32'(n_wr),         32'd0);

      // Address wrap at the top of the bank.
      run_load(10'h3FF, 2, 0, 16, 16'h0300, 0, 0);
      chk("t4_addr7",   32'(obs_addr[7]),  32'h3FF);
      chk("t4_addr8",   32'(obs_addr[8]),  32'h000);
      chk("t4_en8",     32'(obs_en[8]),    32'h01);

      // Reset in the middle of a load, then a fresh start.
      run_load(10'h100, 2, 0, 16, 16'h0100, 0, 5);
      repeat (2) sample();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      run_load(10'h020, 1, 0, 8, 16'h0200, 0, 0);
      chk("t5_en0",     32'(obs_en[0]),    32'h01);
      chk("t5_addr0",   32'(obs_addr[0]),  32'h020);
      chk("t5_data0",   32'(obs_data[0]),  32'h0200);
      chk("t5_writes",  32'(n_wr),         32'd8);

`ifdef DIST_BCAST_EN
      run_load(10'h040, 3, 1, 3, 16'h000A, 0, 0);
      chk("t6_writes",  32'(n_wr),         32'd3);
      chk("t6_en0",     32'(obs_en[0]),    32'hFF);
      chk("t6_addr2",   32'(obs_addr[2]),  32'h042);
      chk("t6_data1",   32'(obs_data[1]),  32'h000B);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
